// File: rtl/dongho_pkg.sv
// Shared definitions for the time-of-day counter: mode-state encoding,
// BCD field limits and the two-digit BCD increment used by every field.
package dongho_pkg;

    typedef enum logic [1:0] {
        CHAY       = 2'd0,
        CHINH_GIO  = 2'd1,
        CHINH_PHUT = 2'd2,
        CHINH_GIAY = 2'd3
    } trang_thai_e;

    localparam logic [7:0] GIAY_MAX = 8'h59;
    localparam logic [7:0] PHUT_MAX = 8'h59;
    localparam logic [7:0] GIO_MAX  = 8'h23;

    // Next value of a packed two-digit BCD count that wraps to 00 after max.
    function automatic logic [7:0] bcd_tang(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/dem_bcd_2so.sv
// Two-digit packed-BCD counter that wraps to 00 after MAX; wrap flags the
// enabled step out of MAX so the caller can chain a carry.
module dem_bcd_2so
    import dongho_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] nap_i,
    output logic [7:0] dem_o,
    output logic       wrap
);

    logic [7:0] dem_q;
    logic [7:0] dem_d;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves dem_d
        // unassigned; otherwise synthesis infers a latch.
        dem_d = dem_q;
        if (en) begin
            dem_d = bcd_tang(dem_q, MAX);
        end
    end

    assign wrap  = en && (dem_q == MAX);
    assign dem_o = dem_q;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            dem_q <= nap_i;
        end else begin
            dem_q <= dem_d;
        end
    end

endmodule

// File: rtl/demgiophutgiay.sv
// Time-of-day counter: hours/minutes/seconds in packed BCD with a button-driven
// setting mode and a one-cycle day-rollover pulse.
module demgiophutgiay
    import dongho_pkg::*;
#(
    parameter logic [7:0] GIO_DAU  = 8'h00,
    parameter logic [7:0] PHUT_DAU = 8'h00,
    parameter logic [7:0] GIAY_DAU = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       nut_chedo,
    input  logic       nut_tang,
    output logic [7:0] gio,
    output logic [7:0] phut,
    output logic [7:0] giay,
    output logic [1:0] dang_chinh,
    output logic       ngay_moi
);

    trang_thai_e trang_thai_q;
    trang_thai_e trang_thai_d;
    logic        ngay_moi_q;
    logic        ngay_moi_d;

    logic chay;
    logic tang_hop_le;
    logic en_giay;
    logic en_phut;
    logic en_gio;
    logic wrap_giay;
    logic wrap_phut;
    logic wrap_gio;

    always_comb begin
        trang_thai_d = trang_thai_q;
        if (nut_chedo) begin
            unique case (trang_thai_q)
                CHAY:       trang_thai_d = CHINH_GIO;
                CHINH_GIO:  trang_thai_d = CHINH_PHUT;
                CHINH_PHUT: trang_thai_d = CHINH_GIAY;
                CHINH_GIAY: trang_thai_d = CHAY;
                default:    trang_thai_d = CHAY;
            endcase
        end
    end

    // A mode press in the same cycle swallows the increment. In run mode the
    // carries chain through wrap flags; while setting, fields never carry.
    assign chay        = (trang_thai_q == CHAY);
    assign tang_hop_le = nut_tang && !nut_chedo;
    assign en_giay     = chay ? tick_1hz  : (tang_hop_le && trang_thai_q == CHINH_GIAY);
    assign en_phut     = chay ? wrap_giay : (tang_hop_le && trang_thai_q == CHINH_PHUT);
    assign en_gio      = chay ? wrap_phut : (tang_hop_le && trang_thai_q == CHINH_GIO);
    assign ngay_moi_d  = chay && wrap_gio;

    dem_bcd_2so #(.MAX(GIAY_MAX)) u_giay (
        .clk   (clk),
        .rst   (rst),
        .en    (en_giay),
        .nap_i (GIAY_DAU),
        .dem_o (giay),
        .wrap  (wrap_giay)
    );

    dem_bcd_2so #(.MAX(PHUT_MAX)) u_phut (
        .clk   (clk),
        .rst   (rst),
        .en    (en_phut),
        .nap_i (PHUT_DAU),
        .dem_o (phut),
        .wrap  (wrap_phut)
    );

    dem_bcd_2so #(.MAX(GIO_MAX)) u_gio (
        .clk   (clk),
        .rst   (rst),
        .en    (en_gio),
        .nap_i (GIO_DAU),
        .dem_o (gio),
        .wrap  (wrap_gio)
    );

    // NOTE: only control state is reset here; the time fields reload their
    // start values inside each counter on the same synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            trang_thai_q <= CHAY;
            ngay_moi_q   <= 1'b0;
        end else begin
            trang_thai_q <= trang_thai_d;
            ngay_moi_q   <= ngay_moi_d;
        end
    end

    assign dang_chinh = trang_thai_q;
    assign ngay_moi   = ngay_moi_q;

endmodule

// File: tb/tb_demgiophutgiay.sv
// Bench for demgiophutgiay: two instances (default and 23:59:58 start values)
// compared against a seconds-of-day reference model.
module tb_demgiophutgiay;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       chedo = 1'b0;
    logic       tang = 1'b0;

    logic [7:0] gio_a, phut_a, giay_a, gio_b, phut_b, giay_b;
    logic [1:0] dang_a, dang_b;
    logic       ng_a, ng_b;

    int checks = 0;
    int errors = 0;

    int mh[2], mm[2], ms[2], mmode[2];
    bit mng[2];
    int dau_h[2] = '{0, 23};
    int dau_m[2] = '{0, 59};
    int dau_s[2] = '{0, 58};

    always #5 clk = ~clk;

    demgiophutgiay u_a (
        .clk(clk), .rst(rst), .tick_1hz(tick), .nut_chedo(chedo), .nut_tang(tang),
        .gio(gio_a), .phut(phut_a), .giay(giay_a), .dang_chinh(dang_a), .ngay_moi(ng_a)
    );

    demgiophutgiay #(.GIO_DAU(8'h23), .PHUT_DAU(8'h59), .GIAY_DAU(8'h58)) u_b (
        .clk(clk), .rst(rst), .tick_1hz(tick), .nut_chedo(chedo), .nut_tang(tang),
        .gio(gio_b), .phut(phut_b), .giay(giay_b), .dang_chinh(dang_b), .ngay_moi(ng_b)
    );

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [26:0] exp_of(input int k);
        return {bcd(mh[k]), bcd(mm[k]), bcd(ms[k]), 2'(mmode[k]), mng[k]};
    endfunction

    function automatic logic [26:0] obs_a();
        return {gio_a, phut_a, giay_a, dang_a, ng_a};
    endfunction

    function automatic logic [26:0] obs_b();
        return {gio_b, phut_b, giay_b, dang_b, ng_b};
    endfunction

    // Reference: run mode advances a seconds-of-day total; setting mode
    // bumps one field modulo its range with no carry.
    task automatic model_step(input int k, input bit r, input bit t, input bit c, input bit i);
        int tot;
        if (r) begin
            mh[k] = dau_h[k]; mm[k] = dau_m[k]; ms[k] = dau_s[k];
            mmode[k] = 0; mng[k] = 1'b0;
            return;
        end
        mng[k] = 1'b0;
        if (mmode[k] == 0) begin
            if (t) begin
                tot = mh[k] * 3600 + mm[k] * 60 + ms[k] + 1;
                if (tot == 86400) begin
                    tot = 0;
                    mng[k] = 1'b1;
                end
                mh[k] = tot / 3600;
                mm[k] = (tot / 60) % 60;
                ms[k] = tot % 60;
            end
        end else if (i && !c) begin
            case (mmode[k])
                1: mh[k] = (mh[k] + 1) % 24;
                2: mm[k] = (mm[k] + 1) % 60;
                default: ms[k] = (ms[k] + 1) % 60;
            endcase
        end
        if (c) mmode[k] = (mmode[k] + 1) % 4;
    endtask

    task automatic do_cycle(input bit r, input bit t, input bit c, input bit i);
        rst = r; tick = t; chedo = c; tang = i;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, t, c, i);
        #1;
        rst = 1'b0; tick = 1'b0; chedo = 1'b0; tang = 1'b0;
    endtask

    task automatic test_reset();
        do_cycle(1, 0, 0, 0);
        do_cycle(1, 1, 1, 1);
        checks++;
        if (obs_a() !== {8'h00, 8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: got %h expected %h", obs_a(), {8'h00, 8'h00, 8'h00, 2'd0, 1'b0});
        end
        checks++;
        if (obs_b() !== {8'h23, 8'h59, 8'h58, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: got %h expected %h", obs_b(), {8'h23, 8'h59, 8'h58, 2'd0, 1'b0});
        end
    endtask

    task automatic test_run_60();
        bit saw59 = 1'b0;
        bit ng_seen = 1'b0;
        do_cycle(1, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            do_cycle(0, 1, 0, 0);
            checks++;
            if (obs_a() !== exp_of(0)) begin
                errors++;
                $display("FAIL run60_step%0d: got %h expected %h", n, obs_a(), exp_of(0));
            end
            if (giay_a === 8'h59) saw59 = 1'b1;
            if (ng_a !== 1'b0) ng_seen = 1'b1;
        end
        checks++;
        if ({phut_a, giay_a} !== {8'h01, 8'h00}) begin
            errors++;
            $display("FAIL run60_end: got %h expected %h", {phut_a, giay_a}, 16'h0100);
        end
        checks++;
        if (!saw59) begin
            errors++;
            $display("FAIL run60_saw59: got %b expected %b", saw59, 1'b1);
        end
        checks++;
        if (ng_seen) begin
            errors++;
            $display("FAIL run60_ngay_moi: got %b expected %b", ng_seen, 1'b0);
        end
    endtask

    task automatic test_rollover();
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 0, 0);
        checks++;
        if (obs_b() !== {8'h23, 8'h59, 8'h59, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL roll_235959: got %h expected %h", obs_b(), {8'h23, 8'h59, 8'h59, 2'd0, 1'b0});
        end
        do_cycle(0, 1, 0, 0);
        checks++;
        if (obs_b() !== {8'h00, 8'h00, 8'h00, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL roll_000000: got %h expected %h", obs_b(), {8'h00, 8'h00, 8'h00, 2'd0, 1'b1});
        end
        do_cycle(0, 0, 0, 0);
        checks++;
        if (obs_b() !== {8'h00, 8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL roll_pulse_end: got %h expected %h", obs_b(), {8'h00, 8'h00, 8'h00, 2'd0, 1'b0});
        end
    endtask

    task automatic test_digit9();
        do_cycle(1, 0, 0, 0);
        for (int n = 0; n < 9; n++) do_cycle(0, 1, 0, 0);
        checks++;
        if (giay_a !== 8'h09) begin
            errors++;
            $display("FAIL d9_giay09: got %h expected %h", giay_a, 8'h09);
        end
        do_cycle(0, 1, 0, 0);
        checks++;
        if (giay_a !== 8'h10) begin
            errors++;
            $display("FAIL d9_giay10: got %h expected %h", giay_a, 8'h10);
        end
        for (int n = 0; n < 589; n++) do_cycle(0, 1, 0, 0);
        checks++;
        if ({phut_a, giay_a} !== 16'h0959) begin
            errors++;
            $display("FAIL d9_phut09: got %h expected %h", {phut_a, giay_a}, 16'h0959);
        end
        do_cycle(0, 1, 0, 0);
        checks++;
        if ({phut_a, giay_a} !== 16'h1000) begin
            errors++;
            $display("FAIL d9_phut10: got %h expected %h", {phut_a, giay_a}, 16'h1000);
        end
        do_cycle(0, 0, 1, 0);
        for (int n = 0; n < 9; n++) do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 1, 0);
        for (int n = 0; n < 49; n++) do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 1, 0);
        for (int n = 0; n < 59; n++) do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 1, 0);
        checks++;
        if (obs_a() !== {8'h09, 8'h59, 8'h59, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL d9_set095959: got %h expected %h", obs_a(), {8'h09, 8'h59, 8'h59, 2'd0, 1'b0});
        end
        do_cycle(0, 1, 0, 0);
        checks++;
        if (obs_a() !== {8'h10, 8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL d9_gio10: got %h expected %h", obs_a(), {8'h10, 8'h00, 8'h00, 2'd0, 1'b0});
        end
    endtask

    task automatic test_setting();
        bit ng_seen = 1'b0;
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 0, 1, 0);
        checks++;
        if (dang_a !== 2'd1) begin
            errors++;
            $display("FAIL set_mode1: got %0d expected %0d", dang_a, 1);
        end
        for (int n = 0; n < 25; n++) begin
            do_cycle(0, 1'($urandom_range(0, 1)), 0, 1);
            checks++;
            if (obs_a() !== exp_of(0)) begin
                errors++;
                $display("FAIL set_inc%0d: got %h expected %h", n, obs_a(), exp_of(0));
            end
            if (ng_a !== 1'b0) ng_seen = 1'b1;
        end
        checks++;
        if (obs_a() !== {8'h01, 8'h00, 8'h00, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL set_gio01: got %h expected %h", obs_a(), {8'h01, 8'h00, 8'h00, 2'd1, 1'b0});
        end
        checks++;
        if (ng_seen) begin
            errors++;
            $display("FAIL set_ngay_moi: got %b expected %b", ng_seen, 1'b0);
        end
        for (int n = 0; n < 3; n++) do_cycle(0, 0, 1, 0);
        do_cycle(0, 1, 0, 0);
        checks++;
        if (obs_a() !== {8'h01, 8'h00, 8'h01, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL set_resume: got %h expected %h", obs_a(), {8'h01, 8'h00, 8'h01, 2'd0, 1'b0});
        end
    endtask

    task automatic test_simultaneous();
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 0, 1, 0);
        do_cycle(0, 0, 1, 0);
        for (int n = 0; n < 5; n++) do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 1, 1);
        checks++;
        if (obs_a() !== {8'h00, 8'h05, 8'h00, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL sim_mode_inc: got %h expected %h", obs_a(), {8'h00, 8'h05, 8'h00, 2'd3, 1'b0});
        end
        do_cycle(0, 0, 1, 0);
        do_cycle(0, 1, 1, 0);
        checks++;
        if (obs_a() !== {8'h00, 8'h05, 8'h01, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL sim_tick_mode: got %h expected %h", obs_a(), {8'h00, 8'h05, 8'h01, 2'd1, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 0, 1, 0);
        for (int n = 0; n < 17; n++) do_cycle(0, 0, 0, 1);
        checks++;
        if ({gio_a, dang_a} !== {8'h17, 2'd1}) begin
            errors++;
            $display("FAIL rmid_gio17: got %h expected %h", {gio_a, dang_a}, {8'h17, 2'd1});
        end
        do_cycle(1, 0, 0, 1);
        checks++;
        if (obs_a() !== {8'h00, 8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_a: got %h expected %h", obs_a(), {8'h00, 8'h00, 8'h00, 2'd0, 1'b0});
        end
        do_cycle(0, 1, 0, 0);
        do_cycle(1, 1, 0, 0);
        checks++;
        if (obs_b() !== {8'h23, 8'h59, 8'h58, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_lost_roll: got %h expected %h", obs_b(), {8'h23, 8'h59, 8'h58, 2'd0, 1'b0});
        end
    endtask

    task automatic test_random();
        do_cycle(1, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            do_cycle(($urandom % 300) == 0, ($urandom % 3) != 0,
                     ($urandom % 10) == 0, ($urandom % 2) == 0);
            checks++;
            if (obs_a() !== exp_of(0)) begin
                errors++;
                $display("FAIL rand_a_%0d: got %h expected %h", n, obs_a(), exp_of(0));
            end
            checks++;
            if (obs_b() !== exp_of(1)) begin
                errors++;
                $display("FAIL rand_b_%0d: got %h expected %h", n, obs_b(), exp_of(1));
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_run_60();
        test_rollover();
        test_digit9();
        test_setting();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
